// File: rtl/phy_rx_link_ctrl.sv
// phy_rx_link_ctrl -- bring-up and recovery sequencer for the PHY RX path.
//
// Walks the RX datapath through soft reset, block alignment, lane deskew
// and run. Alignment loss, deskew failures and packet-filter framing errors
// send it through a one-cycle RETRY. It gives up in FAIL once the retry
// budget is spent. The LTSSM holds i_start high to keep the path up and
// drops it to force IDLE.
//
// Ports:
//   CLK, RST_L         clock, asynchronous active-low reset
//   i_start            LTSSM bring-up request (low forces IDLE)
//   i_Lanes            1: all 32 lanes checked for BA errors, 0: lane 0 only
//   BA_error[31:0]     per-lane block-align error
//   Deskew_error       deskew failure
//   valid_deskew       deskew complete
//   PF_Error           packet-filter framing error
//   o_EN_BA, o_enable_LDS, o_EN_PF          datapath enables
//   o_Soft_RST_blocks, o_rst_BA, o_PIPE_CNT_rst  datapath soft resets
//   o_type_IDL_TS      0: expect TS ordered sets, 1: expect IDL
//   o_link_up, o_fail  status
//   o_state[2:0]       IDLE=0 SRST=1 ALIGN=2 DESKEW=3 RUN=4 RETRY=5 FAIL=6
//
// Optional build macro PHY_RX_LINK_CTRL_ERR_CNT_EN adds the saturating
// retry-cause counters o_ba_err_cnt, o_dsk_err_cnt and o_pf_err_cnt.
`timescale 1ns/1ps

module phy_rx_link_ctrl #(
    parameter int SRST_CYCLES = 4,
    parameter int LOCK_CYCLES = 16,
    parameter int TIMEOUT     = 1024,
    parameter int TMO_WIDTH   = 11,
    parameter int MAX_RETRY   = 3,
    parameter int RETRY_WIDTH = 2
) (
    input  logic        CLK,
    input  logic        RST_L,
    input  logic        i_start,
    input  logic        i_Lanes,
    input  logic [31:0] BA_error,
    input  logic        Deskew_error,
    input  logic        valid_deskew,
    input  logic        PF_Error,
    output logic        o_EN_BA,
    output logic        o_enable_LDS,
    output logic        o_EN_PF,
    output logic        o_Soft_RST_blocks,
    output logic        o_rst_BA,
    output logic        o_PIPE_CNT_rst,
    output logic        o_type_IDL_TS,
    output logic        o_link_up,
    output logic        o_fail,
    output logic [2:0]  o_state
`ifdef PHY_RX_LINK_CTRL_ERR_CNT_EN
    ,
    output logic [7:0]  o_ba_err_cnt,
    output logic [7:0]  o_dsk_err_cnt,
    output logic [7:0]  o_pf_err_cnt
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SRST   = 3'd1;
    localparam logic [2:0] ALIGN  = 3'd2;
    localparam logic [2:0] DESKEW = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;
    localparam logic [2:0] RETRY  = 3'd5;
    localparam logic [2:0] FAIL   = 3'd6;

    // Counters only need to reach their terminal value (N-1).
    localparam int SRST_W = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [SRST_W-1:0]      SRST_LAST = SRST_W'(SRST_CYCLES - 1);
    localparam logic [LOCK_W-1:0]      LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [TMO_WIDTH-1:0]   TMO_LAST  = TMO_WIDTH'(TIMEOUT - 1);
    localparam logic [RETRY_WIDTH-1:0] RETRY_MAX = RETRY_WIDTH'(MAX_RETRY);

    logic [2:0]             state, state_nxt;
    logic [SRST_W-1:0]      srst_cnt;
    logic [LOCK_W-1:0]      lock_cnt;
    logic [TMO_WIDTH-1:0]   tmo_cnt;
    logic [RETRY_WIDTH-1:0] retry_cnt;
    logic                   ba_err;

    assign ba_err = i_Lanes ? (|BA_error) : BA_error[0];

    // Next state. Within a state: errors first, then success, then timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = SRST;
            SRST:   if (srst_cnt == SRST_LAST) state_nxt = ALIGN;
            ALIGN: begin
                if (!ba_err && lock_cnt == LOCK_LAST) state_nxt = DESKEW;
                else if (tmo_cnt == TMO_LAST)         state_nxt = RETRY;
            end
            DESKEW: begin
                if (Deskew_error || ba_err)  state_nxt = RETRY;
                else if (valid_deskew)       state_nxt = RUN;
                else if (tmo_cnt == TMO_LAST) state_nxt = RETRY;
            end
            RUN:    if (PF_Error || Deskew_error || ba_err) state_nxt = RETRY;
            RETRY:  state_nxt = (retry_cnt == RETRY_MAX) ? FAIL : SRST;
            FAIL:   state_nxt = FAIL;
            default: state_nxt = IDLE;
        endcase
        // Dropping i_start overrides everything, IDLE included.
        if (!i_start) state_nxt = IDLE;
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state     <= IDLE;
            srst_cnt  <= '0;
            lock_cnt  <= '0;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            state <= state_nxt;

            // Per-state counters hold zero whenever the FSM is not staying
            // put, so every entry starts them from zero.
            if (state == SRST && state_nxt == SRST) begin
                if (srst_cnt != SRST_LAST) srst_cnt <= srst_cnt + 1'b1;
            end else begin
                srst_cnt <= '0;
            end

            if (state_nxt != ALIGN || ba_err) begin
                lock_cnt <= '0;
            end else if (state == ALIGN && lock_cnt != LOCK_LAST) begin
                lock_cnt <= lock_cnt + 1'b1;
            end

            if ((state == ALIGN || state == DESKEW) && state_nxt == state) begin
                if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if (!i_start || state == IDLE) begin
                retry_cnt <= '0;
            end else if (state == RETRY) begin
                if (retry_cnt != RETRY_MAX) retry_cnt <= retry_cnt + 1'b1;
            end else if (state_nxt == RUN && state != RUN) begin
                retry_cnt <= '0;
            end
        end
    end

`ifdef PHY_RX_LINK_CTRL_ERR_CNT_EN
    // Only DESKEW and RUN can be sent to RETRY by an error; ALIGN timeouts
    // are not attributed to any cause. Within DESKEW, a retry that is
    // neither a BA nor a deskew error is the deskew timeout.
    logic retry_hit;
    assign retry_hit = (state_nxt == RETRY) && (state == DESKEW || state == RUN);

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            o_ba_err_cnt  <= '0;
            o_dsk_err_cnt <= '0;
            o_pf_err_cnt  <= '0;
        end else if (state == IDLE && state_nxt == SRST) begin
            o_ba_err_cnt  <= '0;
            o_dsk_err_cnt <= '0;
            o_pf_err_cnt  <= '0;
        end else if (retry_hit) begin
            if (ba_err) begin
                if (o_ba_err_cnt != 8'hFF) o_ba_err_cnt <= o_ba_err_cnt + 1'b1;
            end else if (Deskew_error || state == DESKEW) begin
                if (o_dsk_err_cnt != 8'hFF) o_dsk_err_cnt <= o_dsk_err_cnt + 1'b1;
            end else begin
                if (o_pf_err_cnt != 8'hFF) o_pf_err_cnt <= o_pf_err_cnt + 1'b1;
            end
        end
    end
`endif

    // Moore decode of the registered state.
    always_comb begin
        o_EN_BA           = 1'b0;
        o_enable_LDS      = 1'b0;
        o_EN_PF           = 1'b0;
        o_Soft_RST_blocks = 1'b0;
        o_rst_BA          = 1'b0;
        o_PIPE_CNT_rst    = 1'b0;
        o_type_IDL_TS     = 1'b0;
        o_link_up         = 1'b0;
        o_fail            = 1'b0;
        case (state)
            SRST: begin
                o_Soft_RST_blocks = 1'b1;
                o_rst_BA          = 1'b1;
                o_PIPE_CNT_rst    = 1'b1;
            end
            ALIGN:  o_EN_BA = 1'b1;
            DESKEW: begin
                o_EN_BA      = 1'b1;
                o_enable_LDS = 1'b1;
            end
            RUN: begin
                o_EN_BA       = 1'b1;
                o_enable_LDS  = 1'b1;
                o_EN_PF       = 1'b1;
                o_type_IDL_TS = 1'b1;
                o_link_up     = 1'b1;
            end
            FAIL:    o_fail = 1'b1;
            default: ;
        endcase
    end

    assign o_state = state;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Directed bench for phy_rx_link_ctrl. Expected per-cycle states are queued
// ahead of the clocks that should produce them, then popped and compared
// one sample per clock, 1 ns after the rising edge.
`timescale 1ns/1ps

module tb_phy_rx_link_ctrl;

    logic        CLK = 1'b0;
    logic        RST_L = 1'b0;
    logic        i_start = 1'b0;
    logic        i_Lanes = 1'b1;
    logic [31:0] BA_error = '0;
    logic        Deskew_error = 1'b0;
    logic        valid_deskew = 1'b0;
    logic        PF_Error = 1'b0;
    logic        o_EN_BA, o_enable_LDS, o_EN_PF, o_Soft_RST_blocks, o_rst_BA;
    logic        o_PIPE_CNT_rst, o_type_IDL_TS, o_link_up, o_fail;
    logic [2:0]  o_state;
`ifdef PHY_RX_LINK_CTRL_ERR_CNT_EN
    logic [7:0]  o_ba_err_cnt, o_dsk_err_cnt, o_pf_err_cnt;
`endif

    phy_rx_link_ctrl dut (
        .CLK(CLK), .RST_L(RST_L), .i_start(i_start), .i_Lanes(i_Lanes),
        .BA_error(BA_error), .Deskew_error(Deskew_error),
        .valid_deskew(valid_deskew), .PF_Error(PF_Error),
        .o_EN_BA(o_EN_BA), .o_enable_LDS(o_enable_LDS), .o_EN_PF(o_EN_PF),
        .o_Soft_RST_blocks(o_Soft_RST_blocks), .o_rst_BA(o_rst_BA),
        .o_PIPE_CNT_rst(o_PIPE_CNT_rst), .o_type_IDL_TS(o_type_IDL_TS),
        .o_link_up(o_link_up), .o_fail(o_fail), .o_state(o_state)
`ifdef PHY_RX_LINK_CTRL_ERR_CNT_EN
        ,
        .o_ba_err_cnt(o_ba_err_cnt), .o_dsk_err_cnt(o_dsk_err_cnt),
        .o_pf_err_cnt(o_pf_err_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        logic [2:0] st;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // {EN_BA, enable_LDS, EN_PF, Soft_RST, rst_BA, PIPE_CNT_rst, type, link_up, fail}
    logic [8:0] outs;
    assign outs = {o_EN_BA, o_enable_LDS, o_EN_PF, o_Soft_RST_blocks, o_rst_BA,
                   o_PIPE_CNT_rst, o_type_IDL_TS, o_link_up, o_fail};

    function automatic logic [8:0] outs_for(logic [2:0] st);
        case (st)
            3'd1:    return 9'b000_111_000;
            3'd2:    return 9'b100_000_000;
            3'd3:    return 9'b110_000_000;
            3'd4:    return 9'b111_000_110;
            3'd6:    return 9'b000_000_001;
            default: return 9'b000_000_000;
        endcase
    endfunction

    task automatic expect_st(input string tag, input logic [2:0] st, input int n);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        repeat (n) sbq.push_back(e);
    endtask

    task automatic check_now(input string tag, input logic [2:0] st);
        logic [8:0] eo;
        eo = outs_for(st);
        n_cmp++;
        assert (o_state === st) else begin
            n_bad++;
            $error("FAIL %s o_state: got %0d expected %0d", tag, o_state, st);
        end
        n_cmp++;
        assert (outs === eo) else begin
            n_bad++;
            $error("FAIL %s outputs: got %b expected %b", tag, outs, eo);
        end
    endtask

    task automatic check_retry(input string tag, input logic [31:0] expv);
        logic [31:0] got;
        got = 32'(dut.retry_cnt);
        n_cmp++;
        assert (got === expv) else begin
            n_bad++;
            $error("FAIL %s retry_cnt: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Drain the scoreboard, one clock per queued entry. valid_deskew is
    // high only during the cycle that produces sample index vd_at.
    task automatic run_q(input int vd_at);
        int   i;
        exp_t e;
        i = 0;
        while (sbq.size() > 0) begin
            valid_deskew = (i == vd_at);
            @(posedge CLK);
            #1;
            e = sbq.pop_front();
            check_now(e.tag, e.st);
            i++;
        end
        valid_deskew = 1'b0;
    endtask

    // From "next sample is SRST": nsrst SRST, 16 ALIGN, 5 DESKEW, then RUN.
    task automatic bring_up(input string tag, input int nsrst);
        expect_st({tag, "_srst"},   3'd1, nsrst);
        expect_st({tag, "_align"},  3'd2, 16);
        expect_st({tag, "_deskew"}, 3'd3, 5);
        expect_st({tag, "_run"},    3'd4, 3);
        run_q(nsrst + 21);
    endtask

    initial begin
        // Reset state
        #12;
        check_now("reset", 3'd0);
        check_retry("reset", 0);
        RST_L = 1'b1;
        expect_st("idle_hold", 3'd0, 2);
        run_q(-1);

        // Clean bring-up on all lanes
        i_start = 1'b1;
        bring_up("clean", 4);
        check_retry("clean_run", 0);

        // PF_Error pulse in RUN: one RETRY, full SRST, re-lock
        PF_Error = 1'b1;
        expect_st("pf_retry", 3'd5, 1);
        run_q(-1);
        PF_Error = 1'b0;
        expect_st("pf_srst0", 3'd1, 1);
        run_q(-1);
        check_retry("pf_after_retry", 1);
        bring_up("pf_relock", 3);
        check_retry("pf_run_again", 0);

        // Deskew_error together with valid_deskew: RETRY wins
        i_start = 1'b0;
        expect_st("abort1", 3'd0, 1);
        run_q(-1);
        i_start = 1'b1;
        expect_st("sim_srst", 3'd1, 4);
        expect_st("sim_align", 3'd2, 16);
        expect_st("sim_deskew", 3'd3, 2);
        run_q(-1);
        Deskew_error = 1'b1;
        expect_st("sim_retry", 3'd5, 1);
        run_q(0);
        Deskew_error = 1'b0;
        expect_st("sim_srst2", 3'd1, 1);
        run_q(-1);
        check_retry("sim_retry_cnt", 1);

        // Abort from SRST
        i_start = 1'b0;
        expect_st("srst_abort", 3'd0, 1);
        run_q(-1);
        check_retry("srst_abort", 0);

        // Lane masking: lane 1 error ignored with i_Lanes=0
        i_Lanes  = 1'b0;
        BA_error = 32'h0000_0002;
        i_start  = 1'b1;
        bring_up("lane0", 4);
        i_start = 1'b0;
        expect_st("abort2", 3'd0, 1);
        run_q(-1);

        // Same error with all lanes: no lock, RETRY after 1024 ALIGN cycles
        i_Lanes = 1'b1;
        i_start = 1'b1;
        expect_st("lanes_srst", 3'd1, 4);
        expect_st("lanes_align", 3'd2, 1024);
        expect_st("lanes_retry", 3'd5, 1);
        expect_st("lanes_srst2", 3'd1, 1);
        run_q(-1);
        i_start = 1'b0;
        expect_st("abort3", 3'd0, 1);
        run_q(-1);

        // Retry exhaustion: lane 0 stuck in error
        BA_error = 32'h0000_0001;
        i_start  = 1'b1;
        repeat (4) begin
            expect_st("exh_srst", 3'd1, 4);
            expect_st("exh_align", 3'd2, 1024);
            expect_st("exh_retry", 3'd5, 1);
        end
        expect_st("exh_fail", 3'd6, 3);
        run_q(-1);
        i_start = 1'b0;
        expect_st("exh_idle", 3'd0, 2);
        run_q(-1);
        BA_error = '0;

        // Asynchronous reset in the middle of DESKEW
        i_start = 1'b1;
        expect_st("ar_srst", 3'd1, 4);
        expect_st("ar_align", 3'd2, 16);
        expect_st("ar_deskew", 3'd3, 2);
        run_q(-1);
        #3;
        RST_L = 1'b0;
        #1;
        check_now("async_reset", 3'd0);
        check_retry("async_reset", 0);
        i_start = 1'b0;
        #7;
        RST_L = 1'b1;
        expect_st("post_reset", 3'd0, 1);
        run_q(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/phy_rx_link_ctrl.md
Name: phy_rx_link_ctrl

Overview:
Bring-up and recovery sequencer for the PHY receive path. It drives the block-align, lane-deskew and packet-filter enables, plus the soft resets, of the PHY RX datapath. It walks the path through reset, alignment, deskew and run, and reacts to BA, deskew and packet-filter errors with bounded retries. It sits beside the PHY RX top in the same CLK domain and is controlled by the LTSSM.

Parameters:
SRST_CYCLES, 4, cycles the soft resets are held in SRST (min 1)
LOCK_CYCLES, 16, consecutive error-free cycles required to declare alignment lock
TIMEOUT, 1024, max cycles allowed in ALIGN or DESKEW before a retry
TMO_WIDTH, 11, counter width; must hold TIMEOUT
MAX_RETRY, 3, retries allowed before entering FAIL
RETRY_WIDTH, 2, retry counter width

Ports:
CLK  in  1  single clock
RST_L  in  1  asynchronous active-low reset
i_start  in  1  LTSSM request to bring up or hold the RX path; low forces IDLE
i_Lanes  in  1  1: all 32 lanes are active; 0: lane 0 only
BA_error  in  32  per-lane block-align error; bit 0 = lane 0
Deskew_error  in  1  deskew failure
valid_deskew  in  1  deskew complete
PF_Error  in  1  packet-filter framing error
o_EN_BA  out  1  block-align enable
o_enable_LDS  out  1  lane deskew enable
o_EN_PF  out  1  packet-filter enable
o_Soft_RST_blocks  out  1  soft reset to the framing and filter blocks
o_rst_BA  out  1  block-align reset
o_PIPE_CNT_rst  out  1  PIPE symbol counter reset
o_type_IDL_TS  out  1  0: expect TS ordered sets; 1: expect IDL
o_link_up  out  1  RX path running
o_fail  out  1  retries exhausted
o_state  out  3  encoded state: IDLE=0, SRST=1, ALIGN=2, DESKEW=3, RUN=4, RETRY=5, FAIL=6

Behaviour:
- Moore FSM. All outputs are a combinational decode of the registered state only, so outputs take effect in the cycle the state register updates.
- Reset: state IDLE; all counters 0; every output 0.
- ba_err = i_Lanes ? |BA_error : BA_error[0].
- Priority in every state: i_start=0 → IDLE next cycle, which also clears all counters. Below that, errors beat success, and success beats timeout.
- IDLE: all outputs 0. i_start=1 → SRST; retry_cnt cleared.
- SRST:
  - Outputs: o_Soft_RST_blocks=o_rst_BA=o_PIPE_CNT_rst=1.
  - Held exactly SRST_CYCLES cycles, then → ALIGN.
  - The lock and timeout counters are cleared on entry.
- ALIGN:
  - Outputs: o_EN_BA=1, o_type_IDL_TS=0.
  - lock_cnt increments each cycle with ba_err=0 and clears to 0 on ba_err=1.
  - lock_cnt reaching LOCK_CYCLES-1 while ba_err=0 → DESKEW.
  - Otherwise, tmo_cnt reaching TIMEOUT-1 → RETRY.
- DESKEW:
  - Outputs: o_EN_BA=o_enable_LDS=1, o_type_IDL_TS=0. tmo_cnt restarts at 0 on entry.
  - Deskew_error=1 or ba_err=1 → RETRY, even if valid_deskew=1 in the same cycle.
  - valid_deskew=1 → RUN.
  - tmo_cnt reaching TIMEOUT-1 → RETRY.
- RUN:
  - Outputs: o_EN_BA=o_enable_LDS=o_EN_PF=1, o_type_IDL_TS=1, o_link_up=1.
  - retry_cnt is cleared on entry.
  - PF_Error, Deskew_error or ba_err → RETRY.
- RETRY:
  - One cycle, all outputs 0.
  - retry_cnt==MAX_RETRY → FAIL; else retry_cnt+1 → SRST.
- FAIL: o_fail=1 and all enables 0. Stays in FAIL until i_start=0 (→ IDLE).
- Counters saturate and never wrap. tmo_cnt does not count in SRST, RUN, RETRY or FAIL.
- Asynchronous reset mid-sequence returns everything to the reset values immediately.

Optional Feature:
- Macro: PHY_RX_LINK_CTRL_ERR_CNT_EN.
- When defined, adds three outputs:
  - o_ba_err_cnt[7:0]: counts RETRY entries caused by ba_err.
  - o_dsk_err_cnt[7:0]: counts RETRY entries caused by Deskew_error or a DESKEW timeout.
  - o_pf_err_cnt[7:0]: counts RETRY entries caused by PF_Error.
- The counters saturate at 255, clear on RST_L and on the IDLE→SRST transition, and must not affect FSM timing.
- When multiple causes are present in one cycle, only the highest-priority cause is counted: ba_err, then Deskew_error, then PF_Error.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Clean bring-up: i_start=1, errors 0, valid_deskew rises 5 cycles into DESKEW → o_state 0→1 (4 cycles)→2 (16 cycles)→3 (5 cycles)→4; o_link_up=1 and o_type_IDL_TS=1.
- Lane masking: i_Lanes=0, BA_error=32'h0000_0002 held throughout ALIGN → lock is still reached in 16 cycles. Same stimulus with i_Lanes=1 → no lock, RETRY at TIMEOUT=1024.
- Simultaneous events: Deskew_error=1 and valid_deskew=1 in the same DESKEW cycle → RETRY, not RUN; retry_cnt becomes 1.
- Retry exhaustion: BA_error[0] stuck at 1 → four ALIGN timeouts, then o_state=6 and o_fail=1. Deasserting i_start → IDLE with all outputs 0.
- Run-time error: PF_Error pulse in RUN → one RETRY cycle, then SRST with o_Soft_RST_blocks=1 for 4 cycles, then re-lock. retry_cnt is cleared on reaching RUN again.
- Reset and abort: RST_L low mid-DESKEW → all outputs 0 asynchronously. i_start=0 in SRST → IDLE on the next cycle.
